noc_cpu_cpu_mult_ctrl: RTL and testbench
========================================

NOC_CPU_CPU_MULT_CTRL -- requirements
Module: noc_cpu_cpu_mult_ctrl

Interface
REQ-001 Parameter USE_HI, default 1: 1 = high-word ops use a second cell pass; 0 = every op returns the low word after one pass.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_src1  input  32  operand A.
REQ-007 req_src2  input  32  operand B.
REQ-008 req_op  input  2  operation: 00 = mul (low word), 01 = mulxuu, 10 = mulxss, 11 = mulxsu (A signed, B unsigned).
REQ-009 cell_src1  output  32  operand to the multiply cell's E_src1.
REQ-010 cell_src2  output  32  operand to the multiply cell's E_src2.
REQ-011 cell_en  output  1  drives the multiply cell's M_en.
REQ-012 cell_p1  input  32  cell product A[15:0]*B[15:0], valid one edge after cell_en.
REQ-013 cell_p2  input  32  cell product A[15:0]*B[31:16].
REQ-014 cell_p3  input  32  cell product A[31:16]*B[15:0].
REQ-015 rsp_valid  output  1  result available.
REQ-016 rsp_ready  input  1  consumer accepts the result.
REQ-017 rsp_result  output  32  result word.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 The block SHALL implement the states IDLE, PASS1, WAIT1, PASS2, WAIT2 and DONE.
REQ-020 req_ready SHALL equal (state == IDLE), and a request SHALL be accepted on a rising edge where req_valid && req_ready.
REQ-021 On acceptance, the block SHALL latch A, B and op, and SHALL move IDLE -> PASS1.
REQ-022 In PASS1, the block SHALL drive cell_src1 = A, cell_src2 = B and cell_en = 1, then move to WAIT1.
REQ-023 In WAIT1, the block SHALL register low = (p1 + ((p2 + p3) << 16)) mod 2^32 and mid = p2 + p3 + (p1 >> 16) (34 bits, no truncation).
REQ-024 From WAIT1, the block SHALL move to DONE when op = 00 or USE_HI = 0, and to PASS2 otherwise.
REQ-025 In PASS2, the block SHALL drive cell_src1 = {16'h0, A[31:16]}, cell_src2 = {16'h0, B[31:16]} and cell_en = 1, then move to WAIT2.
REQ-026 In WAIT2, the block SHALL compute hi = (p1 + (mid >> 16) - corrA - corrB) mod 2^32, where corrA = B if A[31] and op is 10 or 11 (else 0), and corrB = A if B[31] and op = 10 (else 0); it SHALL register hi and move to DONE.
REQ-027 In all states other than PASS1 and PASS2, the block SHALL hold cell_en = 0 and cell_src1 = cell_src2 = 0.
REQ-028 In DONE, rsp_valid SHALL be 1, and rsp_result SHALL be low for op 00 (or USE_HI = 0) and hi otherwise.
REQ-029 While DONE && !rsp_ready, rsp_result and all internal state SHALL hold unchanged.
REQ-030 On DONE && rsp_ready, the block SHALL move to IDLE; the next request can be accepted on the following edge at the earliest.
REQ-031 Latency, counted from the acceptance edge k, SHALL be: rsp_valid rises after edge k+3 for a low-word op, and after edge k+5 for a high-word op.
REQ-032 req_valid and its operands SHALL be ignored outside IDLE, and any change to them outside IDLE SHALL have no effect on the op in flight.
REQ-033 All arithmetic SHALL be modulo 2^32 on the result and SHALL produce no overflow flag.

Reset
REQ-034 While reset_n = 0, the block SHALL be in IDLE with rsp_valid = 0, rsp_result = 0, busy = 0, cell_en = 0, cell_src1 = cell_src2 = 0, req_ready = 1, and all latched operands, low, mid and hi cleared to 0.
REQ-035 Reset asserted in any state, including mid-operation, SHALL abort the op without producing a response; the first request after release SHALL behave identically to one after power-up.

Verification
REQ-036 The bench SHALL cover: op 00, A = 0x0001_0003, B = 0x0002_0005 -> rsp_result = 0x000B_000F, rsp_valid after edge k+3, cell_en high for exactly 1 cycle.
REQ-037 The bench SHALL cover: op 01, A = B = 0xFFFF_FFFF -> rsp_result = 0xFFFF_FFFE after edge k+5, cell_en high for exactly 2 cycles.
REQ-038 The bench SHALL cover: op 10, A = B = 0x8000_0000 -> rsp_result = 0x4000_0000; and op 10, A = B = 0xFFFF_FFFF -> rsp_result = 0x0000_0000.
REQ-039 The bench SHALL cover: op 11, A = 0xFFFF_FFFF, B = 0xFFFF_FFFF -> rsp_result = 0xFFFF_FFFF.
REQ-040 The bench SHALL cover: rsp_ready held low for 4 cycles in DONE, with req_valid = 1 throughout -> rsp_result stable, req_ready = 0, no acceptance; then rsp_ready = 1 -> IDLE, and the new request is accepted on the next edge.
REQ-041 The bench SHALL cover: reset_n pulsed low during PASS2 of an op 01 -> outputs as in REQ-034 immediately; after release, op 00 with A = 3, B = 5 -> rsp_result = 0x0000_000F, with no stale response.

Source files
------------

// File: rtl/noc_cpu_cpu_mult_ctrl.sv
// Multiply controller for a 16x16 split multiply cell.
//
// Sequences one or two passes through an external multiply cell and builds a
// 32-bit result from the partial products it returns:
//   op 00 mul     low word of A*B
//   op 01 mulxuu  high word, A and B unsigned
//   op 10 mulxss  high word, A and B signed
//   op 11 mulxsu  high word, A signed, B unsigned
// With USE_HI = 0 every op returns the low word after a single pass.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; operands req_src1/2, req_op
//   cell_src1/2, cell_en  operands and enable driven to the multiply cell
//   cell_p1/p2/p3         cell partial products, valid one edge after cell_en
//   rsp_valid/rsp_ready   response handshake; result in rsp_result
//   busy                  high whenever the controller is not idle
module noc_cpu_cpu_mult_ctrl #(
  parameter int unsigned USE_HI = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic [1:0]  req_op,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        busy
);

  localparam bit HiEn = (USE_HI != 0);

  typedef enum logic [2:0] {
    StIdle,
    StPass1,
    StWait1,
    StPass2,
    StWait2,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, b_q;
  logic [1:0]  op_q;
  logic [31:0] low_q, low_d;
  logic [33:0] mid_q, mid_d;
  logic [31:0] hi_q, hi_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        accept;
  logic        use_low;
  logic [31:0] corr_a, corr_b;

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign accept    = req_valid && req_ready;
  assign use_low   = (op_q == 2'b00) || !HiEn;

  // Two's-complement corrections turning the unsigned high word into the
  // signed one: subtract B when A is negative, A when B is negative.
  assign corr_a = (a_q[31] && op_q[1]) ? b_q : 32'h0;
  assign corr_b = (b_q[31] && (op_q == 2'b10)) ? a_q : 32'h0;

  always_comb begin
    state_d     = state_q;
    low_d       = low_q;
    mid_d       = mid_q;
    hi_d        = hi_q;
    cell_en     = 1'b0;
    cell_src1   = 32'h0;
    cell_src2   = 32'h0;
    rsp_valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) state_d = StPass1;
      end
      StPass1: begin
        cell_en   = 1'b1;
        cell_src1 = a_q;
        cell_src2 = b_q;
        state_d   = StWait1;
      end
      StWait1: begin
        low_d   = cell_p1 + 32'((33'(cell_p2) + 33'(cell_p3)) << 16);
        // Middle column kept at full width so its carry reaches the high word.
        mid_d   = 34'(cell_p2) + 34'(cell_p3) + 34'(cell_p1 >> 16);
        state_d = use_low ? StDone : StPass2;
      end
      StPass2: begin
        cell_en   = 1'b1;
        cell_src1 = {16'h0, a_q[31:16]};
        cell_src2 = {16'h0, b_q[31:16]};
        state_d   = StWait2;
      end
      StWait2: begin
        hi_d    = cell_p1 + 32'(mid_q >> 16) - corr_a - corr_b;
        state_d = StDone;
      end
      StDone: begin
        // The response register adds one cycle after the final product is
        // latched; the handshake completes only once rsp_valid is visible.
        rsp_valid_d = !(rsp_valid_q && rsp_ready);
        if (rsp_valid_q && rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_valid_q ? (use_low ? low_q : hi_q) : 32'h0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      a_q         <= 32'h0;
      b_q         <= 32'h0;
      op_q        <= 2'b00;
      low_q       <= 32'h0;
      mid_q       <= 34'h0;
      hi_q        <= 32'h0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      low_q       <= low_d;
      mid_q       <= mid_d;
      hi_q        <= hi_d;
      rsp_valid_q <= rsp_valid_d;
      if (accept) begin
        a_q  <= req_src1;
        b_q  <= req_src2;
        op_q <= req_op;
      end
    end
  end

endmodule

// File: tb/tb_noc_cpu_cpu_mult_ctrl.sv
// Directed bench for noc_cpu_cpu_mult_ctrl with a behavioural multiply cell.
module tb_noc_cpu_cpu_mult_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_src1, req_src2;
  logic [1:0]  req_op;
  logic [31:0] cell_src1, cell_src2;
  logic        cell_en;
  logic [31:0] cell_p1 = 32'h0;
  logic [31:0] cell_p2 = 32'h0;
  logic [31:0] cell_p3 = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  noc_cpu_cpu_mult_ctrl #(.USE_HI(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .req_op     (req_op),
    .cell_src1  (cell_src1),
    .cell_src2  (cell_src2),
    .cell_en    (cell_en),
    .cell_p1    (cell_p1),
    .cell_p2    (cell_p2),
    .cell_p3    (cell_p3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  // Multiply cell: partial products registered on the edge that sees cell_en.
  always @(posedge clk) begin
    if (cell_en) begin
      cell_p1 <= cell_src1[15:0] * cell_src2[15:0];
      cell_p2 <= cell_src1[15:0] * cell_src2[31:16];
      cell_p3 <= cell_src1[31:16] * cell_src2[15:0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and let the acceptance edge pass; operands are then
  // scrambled so a controller that re-reads them gives a wrong answer.
  task automatic accept(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    chk({tag, "_ready"}, 32'(req_ready), 32'h1);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    step();
    req_valid = 1'b0;
    req_src1  = $urandom();
    req_src2  = $urandom();
    req_op    = 2'($urandom_range(0, 3));
  endtask

  // Called just after the acceptance edge k; checks rsp_valid stays low until
  // edge k+lat and cell_en pulse count, then optionally completes the handshake.
  task automatic finish_op(input string tag, input logic [31:0] exp, input int lat,
                           input int en_exp, input bit ack);
    int   en_cnt;
    logic early;
    en_cnt = int'(cell_en);
    early  = rsp_valid;
    for (int j = 1; j <= lat; j++) begin
      step();
      if (j < lat) begin
        en_cnt += int'(cell_en);
        early  |= rsp_valid;
      end
    end
    chk({tag, "_early"}, 32'(early), 32'h0);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'h1);
    chk({tag, "_result"}, rsp_result, exp);
    chk({tag, "_en_cycles"}, 32'(en_cnt), 32'(en_exp));
    if (ack) begin
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk({tag, "_idle_ready"}, 32'(req_ready), 32'h1);
      chk({tag, "_idle_valid"}, 32'(rsp_valid), 32'h0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_result"}, rsp_result, 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_en"}, 32'(cell_en), 32'h0);
    chk({tag, "_src1"}, cell_src1, 32'h0);
    chk({tag, "_src2"}, cell_src2, 32'h0);
    chk({tag, "_ready"}, 32'(req_ready), 32'h1);
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_src1  = 32'h0;
    req_src2  = 32'h0;
    req_op    = 2'b00;
    rsp_ready = 1'b0;
    step();
    step();
    chk_reset_outputs("por");
    reset_n = 1'b1;
    step();

    // Low word, cell used once.
    accept("mul", 2'b00, 32'h0001_0003, 32'h0002_0005);
    finish_op("mul", 32'h000B_000F, 3, 1, 1'b1);
    accept("mul_neg", 2'b00, 32'hFFFF_FFFF, 32'h0000_0002);
    finish_op("mul_neg", 32'hFFFF_FFFE, 3, 1, 1'b1);

    // High words, cell used twice.
    accept("mulxuu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("mulxuu", 32'hFFFF_FFFE, 5, 2, 1'b1);
    accept("mulxss_min", 2'b10, 32'h8000_0000, 32'h8000_0000);
    finish_op("mulxss_min", 32'h4000_0000, 5, 2, 1'b1);
    accept("mulxss_m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("mulxss_m1", 32'h0000_0000, 5, 2, 1'b1);
    accept("mulxss_m2x3", 2'b10, 32'hFFFF_FFFE, 32'h0000_0003);
    finish_op("mulxss_m2x3", 32'hFFFF_FFFF, 5, 2, 1'b1);
    accept("mulxsu", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("mulxsu", 32'hFFFF_FFFF, 5, 2, 1'b1);
    // B has bit 31 set but is unsigned for mulxsu: 2 * 2^31 -> high word 1.
    accept("mulxsu_bneg", 2'b11, 32'h0000_0002, 32'h8000_0000);
    finish_op("mulxsu_bneg", 32'h0000_0001, 5, 2, 1'b1);

    // Back-pressure: result held for 4 cycles while a new request waits.
    accept("hold", 2'b00, 32'h0000_0007, 32'h0000_0006);
    finish_op("hold", 32'h0000_002A, 3, 1, 1'b0);
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_src1  = 32'h0000_0100;
    req_src2  = 32'h0000_0100;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_result", rsp_result, 32'h0000_002A);
      chk("hold_valid", 32'(rsp_valid), 32'h1);
      chk("hold_ready", 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("hold_release_ready", 32'(req_ready), 32'h1);
    chk("hold_release_valid", 32'(rsp_valid), 32'h0);
    step();
    req_valid = 1'b0;
    req_src1  = $urandom();
    req_src2  = $urandom();
    chk("queued_busy", 32'(busy), 32'h1);
    finish_op("queued", 32'h0001_0000, 3, 1, 1'b1);

    // Reset during the second pass of a mulxuu.
    accept("abort", 2'b01, 32'hABCD_1234, 32'h5678_9ABC);
    step();
    step();
    chk("abort_pass2_en", 32'(cell_en), 32'h1);
    chk("abort_pass2_src1", cell_src1, 32'h0000_ABCD);
    chk("abort_pass2_src2", cell_src2, 32'h0000_5678);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("abort_rst");
    step();
    step();
    chk_reset_outputs("abort_held");
    reset_n = 1'b1;
    step();
    chk("abort_no_stale", 32'(rsp_valid), 32'h0);
    accept("post_rst", 2'b00, 32'h0000_0003, 32'h0000_0005);
    finish_op("post_rst", 32'h0000_000F, 3, 1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
